// File: rtl/dmem_resp_if.sv
// MEM-stage <-> data-RAM responder bus; master is the MEM stage, slave is dmem_resp.
// The _i/_o suffixes are named from the responder's side.
interface dmem_resp_if #(
   parameter int ADDR_W = 12
);
   logic              mem_we_i;
   logic [3:0]        mem_sel_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [31:0]       mem_data_i;
   logic [31:0]       mem_data_o;
   logic              wb_pending_o;
   logic [15:0]       store_cnt_o;
   logic              misalign_o;

   modport master (
      output mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
      input  mem_data_o, wb_pending_o, store_cnt_o, misalign_o
   );

   modport slave (
      input  mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
      output mem_data_o, wb_pending_o, store_cnt_o, misalign_o
   );
endinterface

// File: rtl/dmem_resp.sv
// Data-RAM responder: lane-steered stores via a 1-entry posted write buffer; 0-cycle loads with byte forwarding; no backpressure.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word stores are dropped and raise a sticky misalign_o.
module dmem_resp #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 2**(ADDR_W-2)
) (
   input  logic       clk,
   input  logic       rst,
   dmem_resp_if.slave bus
);
   localparam int IDX_W = ADDR_W - 2;

   logic [1:0]       off;
   logic [IDX_W-1:0] idx;
   logic [3:0]       lanes;
   logic [31:0]      st_dat;
   logic             misal;
   logic             accept;

   logic             wb_vld_q,   wb_vld_d;
   logic [IDX_W-1:0] wb_idx_q,   wb_idx_d;
   logic [3:0]       wb_lanes_q, wb_lanes_d;
   logic [31:0]      wb_dat_q,   wb_dat_d;
   logic [15:0]      cnt_q,      cnt_d;
   logic             mis_q,      mis_d;

   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      rd_word;

   assign off    = bus.mem_addr_i[1:0];
   assign idx    = bus.mem_addr_i[ADDR_W-1:2];
   // 4-bit shift context drops lanes pushed past byte 3
   assign lanes  = bus.mem_sel_i << off;
   assign st_dat = bus.mem_data_i << {off, 3'b000};

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misal = ((bus.mem_sel_i == 4'b0011) && off[0]) ||
                  ((bus.mem_sel_i == 4'b1111) && (off != 2'd0));
`else
   assign misal = 1'b0;
`endif

   assign accept = bus.mem_we_i && (lanes != 4'd0) && !misal && !rst;

   always_comb begin
      wb_vld_d   = accept;
      wb_idx_d   = wb_idx_q;
      wb_lanes_d = wb_lanes_q;
      wb_dat_d   = wb_dat_q;
      if (accept) begin
         wb_idx_d   = idx;
         wb_lanes_d = lanes;
         wb_dat_d   = st_dat;
      end
      cnt_d = cnt_q + {15'd0, accept};
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_d = mis_q | (bus.mem_we_i & misal);
`else
      mis_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_vld_q <= 1'b0;
         cnt_q    <= 16'd0;
         mis_q    <= 1'b0;
      end else begin
         wb_vld_q <= wb_vld_d;
         cnt_q    <= cnt_d;
         mis_q    <= mis_d;
      end
   end

   always_ff @(posedge clk) begin
      wb_idx_q   <= wb_idx_d;
      wb_lanes_q <= wb_lanes_d;
      wb_dat_q   <= wb_dat_d;
   end

   // Any valid entry retires at every non-reset edge, whether or not a new store replaces it
   always_ff @(posedge clk) begin
      if (!rst && wb_vld_q) begin
         for (int k = 0; k < 4; k++) begin
            if (wb_lanes_q[k]) mem_q[wb_idx_q][8*k +: 8] <= wb_dat_q[8*k +: 8];
         end
      end
   end

   always_comb begin
      rd_word = mem_q[idx];
      for (int k = 0; k < 4; k++) begin
         if (wb_vld_q && (wb_idx_q == idx) && wb_lanes_q[k]) rd_word[8*k +: 8] = wb_dat_q[8*k +: 8];
      end
   end

   assign bus.mem_data_o   = (bus.mem_we_i || rst) ? 32'h0 : (rd_word >> {off, 3'b000});
   assign bus.wb_pending_o = wb_vld_q;
   assign bus.store_cnt_o  = cnt_q;
   assign bus.misalign_o   = mis_q;
endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder at the far end of the MEM-stage data-RAM interface. It accepts the stage's low-aligned store data with sel/addr, steers bytes into the correct lanes of a word-organised array through a one-entry posted-write buffer, and returns load data right-aligned so that byte 0 of `mem_data_o` is the addressed byte. Loads are answered in the same cycle, with byte-wise forwarding from the write buffer.

## Interface
Parameters:
- `ADDR_W`, 12: byte-address width (word index bits + 2).
- `DEPTH`, 2**(ADDR_W-2): number of 32-bit words.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_we_i` in 1: 1 = store, 0 = load or idle.
- `mem_sel_i` in 4: low-aligned byte select; 0001 = byte, 0011 = half, 1111 = word.
- `mem_addr_i` in ADDR_W: byte address.
- `mem_data_i` in 32: store data, low-aligned.
- `mem_data_o` out 32: load data, right-aligned, combinational.
- `wb_pending_o` out 1: write buffer holds an undrained entry.
- `store_cnt_o` out 16: count of accepted stores, wraps at 0xFFFF -> 0.
- `misalign_o` out 1: sticky misaligned-store flag (see Configuration).

## Operation
- Definitions: `off = mem_addr_i[1:0]`; `idx = mem_addr_i[ADDR_W-1:2]`.
- Store lane mask: `lanes = (mem_sel_i << off) & 4'hF`. Steered data: `mem_data_i << 8*off`. Lanes shifted past bit 3 are discarded.
- A store is accepted when `mem_we_i`=1 and `lanes`≠0. A store with `lanes`=0 is ignored.
- Write buffer: one entry holding {valid, idx, lanes, data}.
  - On an accepted store, the buffer captures the new entry at the clock edge.
  - If the buffer already held an entry, that old entry is committed to the array at the same edge.
  - With no accepted store and valid=1, the entry drains to the array and valid clears.
  - Back-to-back stores to the same idx: the old entry commits first and the new entry stays buffered. Final memory contents equal program order.
- Load path, combinational: `word` = array[idx] with each lane replaced by buffer data where buffer.valid, buffer.idx==idx and buffer.lanes[k]=1.
  - `mem_data_o = word >> 8*off`, zero-filled at the top. The MEM stage sign- or zero-extends.
- `mem_data_o` is produced whenever `mem_we_i`=0. It is forced to 0 while `mem_we_i`=1 or `rst`=1.
- `store_cnt_o` increments by 1 on each accepted store.
- Out-of-range idx cannot occur: the array has exactly 2**(ADDR_W-2) words.

## Timing
- Load latency: 0 cycles. Data is valid in the same cycle as the address, including data forwarded from a store accepted on the previous edge.
- Store: captured at the edge where it is presented. It reaches the array at the next edge at the latest. `wb_pending_o` is high for at least 1 cycle after each store.
- Reset, at the clk edge with `rst`=1: buffer valid=0 (the pending entry is discarded and not committed), `wb_pending_o`=0, `store_cnt_o`=0, `misalign_o`=0. Array contents are not reset.
- A store presented in the same cycle as `rst`=1 is dropped and not counted.
- No backpressure: one access per cycle, every cycle.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A store is misaligned when sel=0011 with off[0]=1, or sel=1111 with off≠0.
  - A misaligned store writes nothing and is not counted.
  - It sets `misalign_o` at the next edge. The flag stays set until `rst`.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - Misaligned stores write only the in-word lanes given by the mask rule.
  - `misalign_o` is tied to 0.

## Test plan
- Word store then load: SW 0xDEADBEEF @0x010. Next cycle, load @0x010 -> `mem_data_o`=0xDEADBEEF, forwarded from the buffer. Two cycles later the same value is read from the array and `wb_pending_o`=0.
- Byte lanes: SW 0x00000000 @0x020; SB 0x000000AB @0x023; SH 0x00001234 @0x020. Load @0x020 -> 0xAB001234. Load @0x023 -> 0x000000AB.
- Partial forwarding: array word @0x030 = 0x11223344; SB 0x55 @0x031. Same-next-cycle load @0x030 -> 0x11225544.
- Back-to-back same word: SW 0x1 @0x040, then SW 0x2 @0x040, then idle 2 cycles. Load -> 0x2. `store_cnt_o` += 2.
- Reset mid-buffer: SW 0xCAFEF00D @0x050 with prior word 0x0, then `rst`=1 for 1 cycle. Load @0x050 -> 0x0. `store_cnt_o`=0, `wb_pending_o`=0.
- Misalign, macro defined: SW 0xFFFFFFFF @0x062 -> word @0x060 unchanged, `misalign_o`=1 next cycle, counter unchanged. Macro undefined: word @0x060 upper half becomes 0xFFFF, `misalign_o`=0.
